brush_painter: RTL and testbench

Brush stroke controller between the SPI command path and the frame buffer write port. It queues decoded brush updates (x, y) and latches the current paint color from config updates. For each queued update it writes a square brush of (brushSize+1)×(brushSize+1) pixels into the frame buffer, one pixel per granted cycle. It stalls whenever the display-side arbiter withholds the write grant.

---
 rtl/brush_painter_if.sv | 24 ++
 rtl/brush_painter.sv | 179 +++++++++++++++++
 tb/tb_brush_painter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brush_painter_if.sv
// Frame buffer write port between the brush painter and the display arbiter.
// The painter holds fbWe/fbAddr/fbData stable until the arbiter grants the write.
interface brush_painter_if #(
    parameter int AW = 15
);
    logic          fbGrant;
    logic          fbWe;
    logic [AW-1:0] fbAddr;
    logic [2:0]    fbData;

    modport master (
        input  fbGrant,
        output fbWe,
        output fbAddr,
        output fbData
    );

    modport slave (
        output fbGrant,
        input  fbWe,
        input  fbAddr,
        input  fbData
    );
endinterface

// File: rtl/brush_painter.sv
// Brush stroke controller: queues (x,y) brush updates and paints a square
// of (brushSize+1)^2 pixels per update into the frame buffer.
module brush_painter #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int AW     = 15,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 brushUpdate,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    input  logic                 updateConfig,
    input  logic [2:0]           newColorUpdate,
    input  logic [1:0]           brushSize,
    brush_painter_if.master      fb,
    output logic                 busy,
    output logic                 overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PAINT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [7:0]    cx_q, cx_d;
    logic [7:0]    cy_q, cy_d;
    logic [1:0]    dx_q, dx_d;
    logic [1:0]    dy_q, dy_d;
    logic [1:0]    size_q, size_d;
    logic [2:0]    col_q, col_d;
    logic [2:0]    color_q, color_d;
    logic          fb_we_q, fb_we_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]    fb_data_q, fb_data_d;
    logic          busy_q, busy_d;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf;
    logic [8:0]    px;
    logic [8:0]    py;
    logic          inb;
    logic [AW-1:0] addr;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        size_d    = size_q;
        col_d     = col_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        pop       = 1'b0;

        empty   = (cnt_q == '0);
        full    = (cnt_q == FULL_CNT);
        color_d = updateConfig ? newColorUpdate : color_q;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    {cx_d, cy_d} = mem_q[rd_q];
                    size_d     = brushSize;
                    col_d      = color_q;
                    dx_d       = 2'd0;
                    dy_d       = 2'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                fb_data_d = col_q;
                state_d   = PAINT;
            end
            PAINT: begin
                // Clipped pixels advance without waiting for a grant.
                if (!fb_we_q || fb.fbGrant) begin
                    if (dx_q == size_q && dy_q == size_q) begin
                        state_d = IDLE;
                    end else if (dx_q == size_q) begin
                        dx_d = 2'd0;
                        dy_d = dy_q + 2'd1;
                    end else begin
                        dx_d = dx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        px   = {1'b0, cx_q} + {7'd0, dx_d};
        py   = {1'b0, cy_q} + {7'd0, dy_d};
        inb  = (int'(px) < WIDTH) && (int'(py) < HEIGHT);
        addr = AW'(int'(py) * WIDTH + int'(px));

        fb_we_d = 1'b0;
        if (state_d == PAINT) begin
            fb_we_d   = inb;
            fb_addr_d = addr;
        end

        push = brushUpdate && (!full || pop);
        ovf  = brushUpdate && full && !pop;
        if (push) begin
            mem_d[wr_q] = {x, y};
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

        busy_d = (state_d != IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_q     <= '{default: '0};
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            size_q    <= '0;
            col_q     <= '0;
            color_q   <= 3'b111;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            size_q    <= size_d;
            col_q     <= col_d;
            color_q   <= color_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign fb.fbWe   = fb_we_q;
    assign fb.fbAddr = fb_addr_q;
    assign fb.fbData = fb_data_q;
    assign busy      = busy_q;
    assign overflow  = ovf && !reset;

endmodule

// File: tb/tb_brush_painter.sv
// Bench for brush_painter: pixel-list reference model checked every cycle,
// directed scenarios pinned with literal addresses, then random traffic.
module tb_brush_painter;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int AW    = 15;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       brushUpdate = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       updateConfig = 1'b0;
    logic [2:0] newColorUpdate = '0;
    logic [1:0] brushSize = '0;
    logic       busy;
    logic       overflow;

    brush_painter_if #(.AW(AW)) fb ();

    brush_painter #(
        .WIDTH(W),
        .HEIGHT(H),
        .AW(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .brushUpdate(brushUpdate),
        .x(x),
        .y(y),
        .updateConfig(updateConfig),
        .newColorUpdate(newColorUpdate),
        .brushSize(brushSize),
        .fb(fb),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       addr;
        bit       inb;
        bit [2:0] col;
    } pix_t;

    bit [15:0] mq[$];
    pix_t      pq[$];
    bit        load_gap = 1'b0;
    bit [2:0]  mcolor = 3'b111;
    bit        mvalid = 1'b0;
    int        npass = 0;
    int        ntot = 0;
    int        wa[$];
    int        wd[$];
    bit        ew;
    bit        midle;

    function automatic void chk(string name, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Model: FIFO of entries plus the list of pixels still to be painted.
    task automatic model_step();
        bit    idle;
        bit    pop_ok;
        pix_t  t;
        bit [15:0] e;
        int    s;
        if (reset) begin
            mq.delete();
            pq.delete();
            load_gap = 1'b0;
            mcolor   = 3'b111;
            mvalid   = 1'b1;
            return;
        end
        idle   = !load_gap && pq.size() == 0;
        pop_ok = idle && mq.size() > 0;
        if (load_gap) load_gap = 1'b0;
        else if (pq.size() > 0) begin
            if (!pq[0].inb || fb.fbGrant) t = pq.pop_front();
        end
        if (pop_ok) begin
            e = mq.pop_front();
            s = int'(brushSize);
            for (int dy = 0; dy <= s; dy++) begin
                for (int dx = 0; dx <= s; dx++) begin
                    pix_t p;
                    int   px;
                    int   py;
                    px     = int'(e[15:8]) + dx;
                    py     = int'(e[7:0]) + dy;
                    p.inb  = (px < W) && (py < H);
                    p.addr = (py * W + px) % (1 << AW);
                    p.col  = mcolor;
                    pq.push_back(p);
                end
            end
            load_gap = 1'b1;
        end
        if (brushUpdate && mq.size() < DEPTH) mq.push_back({x, y});
        if (updateConfig) mcolor = newColorUpdate;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                ew    = !load_gap && pq.size() > 0 && pq[0].inb;
                midle = !load_gap && pq.size() == 0;
                chk("fbWe", int'(fb.fbWe), int'(ew));
                if (ew) begin
                    chk("fbAddr", int'(fb.fbAddr), pq[0].addr);
                    chk("fbData", int'(fb.fbData), int'(pq[0].col));
                end
                chk("busy", int'(busy),
                    int'(load_gap || pq.size() > 0 || mq.size() > 0));
                chk("overflow", int'(overflow),
                    int'(!reset && brushUpdate && mq.size() == DEPTH &&
                         !(midle && mq.size() > 0)));
                if (fb.fbWe && fb.fbGrant) begin
                    wa.push_back(int'(fb.fbAddr));
                    wd.push_back(int'(fb.fbData));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int px, input int py, input int sz);
        x           = 8'(px);
        y           = 8'(py);
        brushSize   = 2'(sz);
        brushUpdate = 1'b1;
        tick();
        brushUpdate = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    function automatic int wa_at(input int i);
        return (i < wa.size()) ? wa[i] : -1;
    endfunction

    int sq2[4] = '{805, 806, 965, 966};
    int ov5[5] = '{0, 10, 20, 30, 40};
    int nold;

    initial begin
        fb.fbGrant = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fbWe", int'(fb.fbWe), 0);
        chk("rst_fbAddr", int'(fb.fbAddr), 0);
        chk("rst_fbData", int'(fb.fbData), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);

        // single pixel
        updateConfig   = 1'b1;
        newColorUpdate = 3'b100;
        tick();
        updateConfig = 1'b0;
        wa.delete();
        wd.delete();
        push(10, 20, 0);
        tick();
        tick();
        chk("px_we", int'(fb.fbWe), 1);
        chk("px_addr", int'(fb.fbAddr), 3210);
        chk("px_data", int'(fb.fbData), 4);
        tick();
        chk("px_we_after", int'(fb.fbWe), 0);
        chk("px_busy_after", int'(busy), 0);
        chk("px_nwrites", wa.size(), 1);

        // 2x2 square
        wa.delete();
        push(5, 5, 1);
        wait_idle(50);
        chk("sq2_n", wa.size(), 4);
        for (int i = 0; i < 4; i++) chk("sq2_addr", wa_at(i), sq2[i]);

        // edge clipping
        wa.delete();
        push(159, 119, 1);
        repeat (5) tick();
        chk("clip_busy_c6", int'(busy), 1);
        tick();
        chk("clip_busy_c7", int'(busy), 0);
        chk("clip_n", wa.size(), 1);
        chk("clip_addr", wa_at(0), 19199);

        // stall
        wa.delete();
        push(5, 5, 1);
        tick();
        fb.fbGrant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_we", int'(fb.fbWe), 1);
            chk("stall_addr", int'(fb.fbAddr), 805);
        end
        fb.fbGrant = 1'b1;
        wait_idle(50);
        chk("stall_n", wa.size(), 4);
        for (int i = 0; i < 4; i++) chk("stall_addr_seq", wa_at(i), sq2[i]);

        // overflow
        wa.delete();
        fb.fbGrant = 1'b0;
        brushSize  = 2'd0;
        for (int k = 0; k < 6; k++) begin
            x           = 8'(k * 10);
            y           = 8'd0;
            brushUpdate = 1'b1;
            #1;
            chk("ovf_pulse", int'(overflow), int'(k == 5));
            tick();
        end
        brushUpdate = 1'b0;
        repeat (3) tick();
        fb.fbGrant = 1'b1;
        wait_idle(200);
        chk("ovf_n", wa.size(), 5);
        for (int i = 0; i < 5; i++) chk("ovf_order", wa_at(i), ov5[i]);

        // color change mid-square
        wa.delete();
        wd.delete();
        push(20, 10, 3);
        tick();
        brushSize = 2'd0;
        tick();
        push(0, 1, 0);
        tick();
        updateConfig   = 1'b1;
        newColorUpdate = 3'b010;
        tick();
        updateConfig = 1'b0;
        wait_idle(100);
        chk("col_n", wa.size(), 17);
        chk("col_first_addr", wa_at(0), 1620);
        nold = 0;
        for (int i = 0; i < 16 && i < wd.size(); i++) if (wd[i] == 4) nold++;
        chk("col_old_kept", nold, 16);
        chk("col_next_addr", wa_at(16), 160);
        chk("col_next_data", (wd.size() > 16) ? wd[16] : -1, 2);

        // reset mid-square
        push(10, 10, 3);
        push(30, 30, 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_we", int'(fb.fbWe), 0);
        chk("rst_mid_busy", int'(busy), 0);
        push(3, 3, 0);
        tick();
        tick();
        chk("rst_col_we", int'(fb.fbWe), 1);
        chk("rst_col_addr", int'(fb.fbAddr), 483);
        chk("rst_col_data", int'(fb.fbData), 7);
        wait_idle(50);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            brushUpdate    = ($urandom % 4) == 0;
            x              = ($urandom % 2) ? 8'($urandom_range(150, 165))
                                            : 8'($urandom);
            y              = ($urandom % 2) ? 8'($urandom_range(112, 125))
                                            : 8'($urandom);
            brushSize      = 2'($urandom);
            fb.fbGrant     = ($urandom % 4) != 0;
            updateConfig   = ($urandom % 16) == 0;
            newColorUpdate = 3'($urandom);
            reset          = ($urandom % 700) == 0;
            tick();
        end
        brushUpdate  = 1'b0;
        updateConfig = 1'b0;
        reset        = 1'b0;
        fb.fbGrant   = 1'b1;
        tick();
        wait_idle(500);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
